// File: rtl/la_pkg.sv
// la_pkg: shared state encoding and AXIS tuser bit positions for the logic-analyzer RLE capture
package la_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;
  localparam int TU_DROP  = 0;
  localparam int TU_FIRST = 1;
endpackage

// File: rtl/la_sync_fifo.sv
// la_sync_fifo: single-clock show-ahead FIFO; a write into a full FIFO succeeds when a read happens in the same cycle
module la_sync_fifo #(
  parameter int pWIDTH = 35,
  parameter int pDEPTH = 16,
  localparam int AW = $clog2(pDEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [pWIDTH-1:0] i_wdata,
  input  logic              i_rd,
  output logic [pWIDTH-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level
);
  logic [pWIDTH-1:0] r_mem [pDEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_level;
  logic              w_rd, w_wr;
  assign o_empty = r_level == '0;
  assign o_full  = r_level == (AW+1)'(pDEPTH);
  assign o_level = r_level;
  assign w_rd    = i_rd & ~o_empty;
  assign w_wr    = i_wr & (~o_full | w_rd);
  // Gate the head word so outputs read as zero while empty, including right after reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rp];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wp] <= i_wdata;
endmodule

// File: rtl/la_rle_capture.sv
// la_rle_capture: triggered run-length capture of masked probe samples into {count,data} AXI-Stream words
module la_rle_capture
  import la_pkg::*;
#(
  parameter int pDATA_WIDTH = 24,
  parameter int pCNT_WIDTH  = 8,
  parameter int pFIFO_DEPTH = 16
) (
  input  logic                            axi_clk,
  input  logic                            axi_reset_n,
  input  logic                            cfg_enable,
  input  logic                            cfg_flush,
  input  logic [pDATA_WIDTH-1:0]          cfg_mask,
  input  logic [pDATA_WIDTH-1:0]          cfg_trig_val,
  input  logic [pDATA_WIDTH-1:0]          cfg_trig_mask,
  input  logic [pDATA_WIDTH-1:0]          up_la_data,
  output logic [pCNT_WIDTH+pDATA_WIDTH-1:0] m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [1:0]                      m_tuser,
  output logic                            la_hpri_req,
  output logic [15:0]                     drop_count,
  output logic [1:0]                      la_state
);
  localparam int WW = pCNT_WIDTH + pDATA_WIDTH;
  localparam int FW = WW + 3;
  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam logic [pCNT_WIDTH-1:0] MAX = '1;
  logic [1:0]             r_state;
  logic [pDATA_WIDTH-1:0] r_val;
  logic [pCNT_WIDTH-1:0]  r_cnt;
  logic                   r_first, r_dropf, r_hpri;
  logic [15:0]            r_drop_cnt;
  logic [pDATA_WIDTH-1:0] w_s;
  logic                   w_trig, w_stop, w_brk, w_fl, w_push, w_drop, w_pop, w_space;
  logic                   w_full, w_empty;
  logic [AW:0]            w_level, w_level_nxt;
  logic [FW-1:0]          w_wdata, w_rdata;
  logic [1:0]             w_user;
  assign w_s     = up_la_data & cfg_mask;
  assign w_trig  = ((up_la_data ^ cfg_trig_val) & cfg_trig_mask) == '0;
  assign w_stop  = ~cfg_enable | cfg_flush;
  assign w_pop   = m_tvalid & m_tready;
  assign w_space = ~w_full | w_pop;
  // A run breaks on a new value or when the count field is saturated.
  assign w_brk   = (r_state == ST_RUN) & ~w_stop & ((w_s != r_val) | (r_cnt == MAX));
  assign w_fl    = r_state == ST_FLUSH;
  assign w_push  = (w_brk | w_fl) & w_space;
  assign w_drop  = w_brk & ~w_space;
  always_comb begin
    w_user           = '0;
    w_user[TU_DROP]  = r_dropf;
    w_user[TU_FIRST] = r_first;
  end
  assign w_wdata     = {r_cnt, r_val, w_fl, w_user};
  assign w_level_nxt = w_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  la_sync_fifo #(.pWIDTH(FW), .pDEPTH(pFIFO_DEPTH)) u_fifo (
    .i_clk   (axi_clk),
    .i_rst_n (axi_reset_n),
    .i_wr    (w_push),
    .i_wdata (w_wdata),
    .i_rd    (m_tready),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );
  assign m_tvalid    = ~w_empty;
  assign m_tdata     = w_rdata[FW-1:3];
  assign m_tlast     = w_rdata[2];
  assign m_tuser     = w_rdata[1:0];
  assign la_hpri_req = r_hpri;
  assign drop_count  = r_drop_cnt;
  assign la_state    = r_state;
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) begin
      r_state    <= ST_IDLE;
      r_val      <= '0;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_dropf    <= 1'b0;
      r_hpri     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_hpri <= w_level_nxt >= (AW+1)'(pFIFO_DEPTH / 2);
      case (r_state)
        ST_IDLE:  if (cfg_enable) r_state <= ST_ARMED;
        ST_ARMED:
          if (!cfg_enable) r_state <= ST_IDLE;
          else if (w_trig) begin
            r_state    <= ST_RUN;
            r_val      <= w_s;
            r_cnt      <= pCNT_WIDTH'(1);
            r_drop_cnt <= '0;
            r_first    <= 1'b1;
            r_dropf    <= 1'b0;
          end
        ST_RUN:
          if (w_stop) r_state <= ST_FLUSH;
          else if (w_brk) begin
            r_val <= w_s;
            r_cnt <= pCNT_WIDTH'(1);
          end else r_cnt <= r_cnt + 1'b1;
        default:  if (w_space) r_state <= ST_IDLE;
      endcase
      if (w_push) begin
        r_first <= 1'b0;
        r_dropf <= 1'b0;
      end
      if (w_drop) begin
        r_dropf <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_la_rle_capture.sv
// tb_la_rle_capture: randomized and directed scoreboard bench for la_rle_capture against a queue-based reference model
module tb_la_rle_capture;
  localparam int DW = 24;
  localparam int CW = 8;
  localparam int D  = 16;
  localparam int MAXC = (1 << CW) - 1;
  typedef logic [CW+DW+2:0] word_t;
  logic          axi_clk = 1'b0, axi_reset_n = 1'b0;
  logic          cfg_enable = 1'b0, cfg_flush = 1'b0, m_tready = 1'b0;
  logic [DW-1:0] cfg_mask = '1, cfg_trig_val = '0, cfg_trig_mask = '0, up_la_data = '0;
  logic [CW+DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, la_hpri_req;
  logic [1:0]    m_tuser, la_state;
  logic [15:0]   drop_count;
  la_rle_capture #(.pDATA_WIDTH(DW), .pCNT_WIDTH(CW), .pFIFO_DEPTH(D)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .cfg_enable(cfg_enable), .cfg_flush(cfg_flush),
    .cfg_mask(cfg_mask), .cfg_trig_val(cfg_trig_val), .cfg_trig_mask(cfg_trig_mask),
    .up_la_data(up_la_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .la_hpri_req(la_hpri_req), .drop_count(drop_count),
    .la_state(la_state)
  );
  always #5 axi_clk = ~axi_clk;
  int total = 0, bad = 0;
  word_t exp_q[$], got_q[$];
  // Reference model: capture phase, current run (value,length), FIFO occupancy and drop bookkeeping.
  int m_state, m_count, m_len, m_drop;
  logic [DW-1:0] m_val;
  bit m_first, m_dropf, m_hpri;
  function automatic word_t mk(int n, logic [DW-1:0] v, bit last, bit first, bit dropf);
    logic [CW-1:0] c;
    c = n[CW-1:0];
    return {c, v, last, first, dropf};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic model_reset();
    m_state = 0; m_count = 0; m_len = 0; m_drop = 0; m_val = '0;
    m_first = 0; m_dropf = 0; m_hpri = 0;
    exp_q.delete();
  endtask
  task automatic emit(input bit last, input bit space);
    if (space) begin
      exp_q.push_back(mk(m_len, m_val, last, m_first, m_dropf));
      m_count++;
      m_first = 0;
      m_dropf = 0;
    end else begin
      if (m_drop < 65535) m_drop++;
      m_dropf = 1;
    end
  endtask
  task automatic model_step();
    int pop;
    bit space;
    logic [DW-1:0] s;
    pop   = (m_tready && m_count > 0) ? 1 : 0;
    space = (m_count - pop) < D;
    s     = up_la_data & cfg_mask;
    case (m_state)
      0: if (cfg_enable) m_state = 1;
      1: if (!cfg_enable) m_state = 0;
         else if (((up_la_data ^ cfg_trig_val) & cfg_trig_mask) == '0) begin
           m_state = 2; m_val = s; m_len = 1; m_drop = 0; m_first = 1; m_dropf = 0;
         end
      2: if (cfg_flush || !cfg_enable) m_state = 3;
         else if (s == m_val && m_len < MAXC) m_len++;
         else begin
           emit(0, space);
           m_val = s;
           m_len = 1;
         end
      default: if (space) begin
        emit(1, 1);
        m_state = 0;
      end
    endcase
    m_count -= pop;
    m_hpri = m_count >= D / 2;
  endtask
  task automatic cyc(input logic en, input logic fl, input logic [DW-1:0] d, input logic rdy);
    @(negedge axi_clk);
    cfg_enable = en; cfg_flush = fl; up_la_data = d; m_tready = rdy;
    chk("state", la_state, m_state);
    chk("drop_count", drop_count, m_drop);
    chk("hpri", la_hpri_req, m_hpri);
    chk("tvalid", m_tvalid, m_count > 0);
    model_step();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 1);
  endtask
  task automatic do_reset();
    @(negedge axi_clk);
    cfg_enable = 0; cfg_flush = 0;
    axi_reset_n = 0;
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_state", la_state, 0);
    model_reset();
    @(negedge axi_clk);
    axi_reset_n = 1;
  endtask
  initial begin : monitor
    word_t w, a;
    forever begin
      @(negedge axi_clk);
      #2;
      if (axi_reset_n && m_tvalid && m_tready) begin
        a = {m_tdata, m_tlast, m_tuser};
        got_q.push_back(a);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL word: unexpected %0h with nothing expected", a);
        end else begin
          w = exp_q.pop_front();
          if (a !== w) begin
            bad++;
            $display("FAIL word: got %0h expected %0h at %0t", a, w, $time);
          end
        end
      end
    end
  end
  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "timeout");
  end
  initial begin : stim
    logic [DW-1:0] d;
    int thr, len, gap;
    model_reset();
    #1;
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tvalid0", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_hpri", la_hpri_req, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_state0", la_state, 0);
    @(negedge axi_clk);
    axi_reset_n = 1;
    // basic runs 5,5,5,7 then flush
    got_q.delete();
    cyc(1, 0, 0, 1);
    cyc(1, 0, 5, 1); cyc(1, 0, 5, 1); cyc(1, 0, 5, 1); cyc(1, 0, 7, 1);
    cyc(1, 1, 0, 1);
    idle(6);
    chk("t1_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("t1_w0", got_q[0], mk(3, 5, 0, 1, 0));
      chk("t1_w1", got_q[1], mk(1, 7, 1, 0, 0));
    end
    // count saturation on a long constant run
    got_q.delete();
    cyc(1, 0, 24'hAAAAAA, 1);
    for (int i = 0; i < 300; i++) cyc(1, 0, 24'hAAAAAA, 1);
    cyc(1, 1, 24'hAAAAAA, 1);
    idle(6);
    chk("t2_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("t2_w0", got_q[0], mk(255, 24'hAAAAAA, 0, 1, 0));
      chk("t2_w1", got_q[1], mk(45, 24'hAAAAAA, 1, 0, 0));
    end
    // trigger on value 0x10 in the low byte
    got_q.delete();
    cfg_trig_val = 24'h10; cfg_trig_mask = 24'hFF;
    cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1); cyc(1, 0, 2, 1); cyc(1, 0, 24'h10, 1); cyc(1, 0, 24'h10, 1); cyc(1, 0, 3, 1);
    cyc(1, 1, 0, 1);
    idle(6);
    chk("t3_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("t3_w0", got_q[0], mk(2, 24'h10, 0, 1, 0));
      chk("t3_w1", got_q[1], mk(1, 3, 1, 0, 0));
    end
    // overflow with sink stalled, then flush into a full FIFO
    got_q.delete();
    cfg_trig_mask = '0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, (i % 2) ? 24'd2 : 24'd1, 0);
    cyc(1, 1, 0, 0);
    chk("t4_drop", drop_count, 3);
    chk("t4_hpri", la_hpri_req, 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("t4_hold", la_state, 3);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t4_idle", la_state, 0);
    idle(20);
    chk("t4_count", got_q.size(), 17);
    if (got_q.size() >= 17) begin
      chk("t4_first_user", got_q[0][2:0], 3'b010);
      chk("t4_flush_user", got_q[16][2:0], 3'b101);
    end
    // reset in the middle of a capture with words buffered
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, (i % 2) ? 24'd9 : 24'd4, 0);
    do_reset();
    chk("t5_tvalid", m_tvalid, 0);
    chk("t5_state", la_state, 0);
    idle(4);
    // randomized captures
    for (int c = 0; c < 25; c++) begin
      cfg_mask      = $urandom_range(0, 1) ? '1 : DW'($urandom);
      cfg_trig_val  = DW'($urandom);
      cfg_trig_mask = (c % 8 == 3) ? '0 : DW'($urandom_range(0, 3));
      thr = $urandom_range(1, 10);
      len = (c % 8 == 3) ? 320 : $urandom_range(3, 60);
      d = '0;
      for (int i = 0; i < len; i++) begin
        if (c % 8 != 3 && $urandom_range(0, 9) > 5) d = DW'($urandom_range(0, 3));
        cyc(1, 0, d, $urandom_range(1, 10) <= thr);
      end
      if ($urandom_range(0, 1)) cyc(1, 1, d, $urandom_range(1, 10) <= thr);
      else cyc(0, 0, d, $urandom_range(1, 10) <= thr);
      gap = $urandom_range(1, 6);
      for (int k = 0; k < gap; k++) cyc(0, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
    end
    idle(40);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_tvalid", m_tvalid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
